// File: rtl/ribbon_link_tx.sv
// ribbon_link_tx - transmit end of the 34-pin ribbon link between boards.
// Accepts 32-bit words on a valid/ready handshake and sends each word as
// two 16-bit halves (low half first). Each half has odd parity and uses a
// 4-phase STB/ACK handshake with the far-end receiver.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a word; RIB_D/RIB_PAR hold last driven value
// SETUP   | data/parity driven, counting setup cycles before STB rises
// STROBE  | STB high, waiting for synchronised ACK to rise
// RELEASE | STB low, waiting for synchronised ACK to fall
//
// Ports:
//   CLK, RESET_N         clock, async active-low reset
//   TX_DATA/VALID/READY  on-board word handshake (TX_READY combinational)
//   RIB_D, RIB_PAR       ribbon data and odd parity
//   RIB_STB, RIB_ACK     ribbon strobe out, asynchronous acknowledge in
//   TX_ERR, ERR_CLR      sticky handshake-timeout flag and its clear
//   BUSY                 high whenever not in IDLE
module ribbon_link_tx #(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT     = 1023,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] TX_DATA,
  input  logic        TX_VALID,
  output logic        TX_READY,
  output logic [15:0] RIB_D,
  output logic        RIB_PAR,
  output logic        RIB_STB,
  input  logic        RIB_ACK,
  output logic        TX_ERR,
  input  logic        ERR_CLR,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  localparam logic [3:0]  SETUP_LD = 4'(SETUP_CYC);
  // Timeout fires on the edge where the counter has already seen TIMEOUT-1
  // cycles, so TX_ERR appears exactly TIMEOUT cycles after state entry.
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  logic [15:0] upper_q, upper_nxt;
  logic [15:0] d_q, d_nxt;
  logic        par_q, par_nxt;
  logic        stb_q, stb_nxt;
  logic        err_q, err_nxt;
  logic        half_q, half_nxt;
  logic [3:0]  setup_cnt, setup_nxt;
  logic [15:0] to_cnt, to_nxt;
  logic        accept;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) ack_sync <= '0;
    else          ack_sync <= {ack_sync[SYNC_STAGES-2:0], RIB_ACK};
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign TX_READY = (state == IDLE) && !err_q && !ack_s;
  assign accept   = TX_VALID && TX_READY;
  assign BUSY     = (state != IDLE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      upper_q   <= '0;
      d_q       <= '0;
      par_q     <= 1'b1;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
      half_q    <= 1'b0;
      setup_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      upper_q   <= upper_nxt;
      d_q       <= d_nxt;
      par_q     <= par_nxt;
      stb_q     <= stb_nxt;
      err_q     <= err_nxt;
      half_q    <= half_nxt;
      setup_cnt <= setup_nxt;
      to_cnt    <= to_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    upper_nxt = upper_q;
    d_nxt     = d_q;
    par_nxt   = par_q;
    stb_nxt   = stb_q;
    half_nxt  = half_q;
    setup_nxt = setup_cnt;
    to_nxt    = to_cnt;
    // Clear first; a timeout below overrides it so the set wins.
    err_nxt   = ERR_CLR ? 1'b0 : err_q;

    case (state)
      IDLE: begin
        if (accept) begin
          upper_nxt = TX_DATA[31:16];
          d_nxt     = TX_DATA[15:0];
          par_nxt   = ~^TX_DATA[15:0];
          half_nxt  = 1'b0;
          setup_nxt = SETUP_LD;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt == 4'd0) begin
          stb_nxt   = 1'b1;
          to_nxt    = '0;
          state_nxt = STROBE;
        end else begin
          setup_nxt = setup_cnt - 4'd1;
        end
      end
      STROBE: begin
        if (ack_s) begin
          stb_nxt   = 1'b0;
          to_nxt    = '0;
          state_nxt = RELEASE;
        end else if (to_cnt == TO_LAST) begin
          err_nxt   = 1'b1;
          stb_nxt   = 1'b0;
          half_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          to_nxt = to_cnt + 16'd1;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          if (!half_q) begin
            half_nxt  = 1'b1;
            d_nxt     = upper_q;
            par_nxt   = ~^upper_q;
            setup_nxt = SETUP_LD;
            state_nxt = SETUP;
          end else begin
            half_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end else if (to_cnt == TO_LAST) begin
          err_nxt   = 1'b1;
          stb_nxt   = 1'b0;
          half_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          to_nxt = to_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign RIB_D   = d_q;
  assign RIB_PAR = par_q;
  assign RIB_STB = stb_q;
  assign TX_ERR  = err_q;

endmodule

// File: tb/tb_ribbon_link_tx.sv
module tb_ribbon_link_tx;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic [15:0] RIB_D;
  logic        RIB_PAR;
  logic        RIB_STB;
  logic        RIB_ACK;
  logic        TX_ERR;
  logic        ERR_CLR;
  logic        BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  ribbon_link_tx #(.SETUP_CYC(2), .TIMEOUT(1023), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .RIB_D(RIB_D), .RIB_PAR(RIB_PAR), .RIB_STB(RIB_STB),
    .RIB_ACK(RIB_ACK), .TX_ERR(TX_ERR), .ERR_CLR(ERR_CLR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Far-end receiver for one half: waits for STB, captures D/PAR, raises ACK
  // three cycles later, drops it three cycles after STB falls.
  task automatic rx_half(output logic [15:0] d, output logic par,
                         output bit ok, output bit stable);
    int n;
    ok = 1'b1;
    stable = 1'b1;
    n = 0;
    while (RIB_STB !== 1'b1 && n < 100) begin tick(); n++; end
    if (RIB_STB !== 1'b1) ok = 1'b0;
    d = RIB_D;
    par = RIB_PAR;
    repeat (3) begin
      tick();
      if (RIB_STB !== 1'b1 || RIB_D !== d || RIB_PAR !== par) stable = 1'b0;
    end
    RIB_ACK = 1'b1;
    n = 0;
    while (RIB_STB !== 1'b0 && n < 100) begin
      tick();
      if (RIB_STB === 1'b1 && (RIB_D !== d || RIB_PAR !== par)) stable = 1'b0;
      n++;
    end
    if (RIB_STB !== 1'b0) ok = 1'b0;
    repeat (3) tick();
    RIB_ACK = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    TX_DATA  = w;
    TX_VALID = 1'b1;
    tick();
    TX_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; TX_DATA = '0; TX_VALID = 1'b0; RIB_ACK = 1'b0; ERR_CLR = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({RIB_D, RIB_PAR, RIB_STB, TX_ERR, BUSY} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: D=%h PAR=%b STB=%b ERR=%b BUSY=%b, want D=0000 PAR=1 STB=0 ERR=0 BUSY=0",
               RIB_D, RIB_PAR, RIB_STB, TX_ERR, BUSY);
    end
    RESET_N = 1'b1;
    tick();
    n_checks++;
    if (TX_READY !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: TX_READY=%b want 1", TX_READY);
    end
  endtask

  task automatic test_basic();
    logic [15:0] d; logic par; bit ok, st; int n;
    send_word(32'h1234ABCD);
    TX_DATA = 32'hFFFF_FFFF;
    n_checks++;
    // 0xABCD has 10 ones, so odd parity bit is 1
    if (RIB_D !== 16'hABCD || RIB_PAR !== 1'b1 || BUSY !== 1'b1 || TX_READY !== 1'b0 || RIB_STB !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept: D=%h PAR=%b BUSY=%b RDY=%b STB=%b want ABCD 1 1 0 0",
               RIB_D, RIB_PAR, BUSY, TX_READY, RIB_STB);
    end
    tick(); tick();
    n_checks++;
    if (RIB_STB !== 1'b0) begin
      n_fail++; $display("FAIL basic_stb_early: STB=%b two cycles after accept, want 0", RIB_STB);
    end
    tick();
    n_checks++;
    if (RIB_STB !== 1'b1) begin
      n_fail++; $display("FAIL basic_stb_rise: STB=%b three cycles after accept, want 1", RIB_STB);
    end
    rx_half(d, par, ok, st);
    n_checks++;
    if (!ok || !st || d !== 16'hABCD || par !== 1'b1) begin
      n_fail++; $display("FAIL basic_low: D=%h PAR=%b ok=%b stable=%b want ABCD 1 1 1", d, par, ok, st);
    end
    rx_half(d, par, ok, st);
    n_checks++;
    if (!ok || !st || d !== 16'h1234 || par !== 1'b0) begin
      n_fail++; $display("FAIL basic_high: D=%h PAR=%b ok=%b stable=%b want 1234 0 1 1", d, par, ok, st);
    end
    n = 0;
    while (BUSY !== 1'b0 && n < 10) begin tick(); n++; end
    n_checks++;
    if (BUSY !== 1'b0 || TX_READY !== 1'b1 || RIB_D !== 16'h1234) begin
      n_fail++; $display("FAIL basic_done: BUSY=%b RDY=%b D=%h want 0 1 1234", BUSY, TX_READY, RIB_D);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d0, d1, d2, d3; logic p0, p1, p2, p3; bit ok0, ok1, ok2, ok3, s0, s1, s2, s3;
    int n, idle_cyc;
    TX_DATA = 32'h0000FFFF; TX_VALID = 1'b1;
    tick();
    TX_DATA = 32'h00010000;
    rx_half(d0, p0, ok0, s0);
    rx_half(d1, p1, ok1, s1);
    n = 0;
    while (BUSY !== 1'b0 && n < 10) begin tick(); n++; end
    idle_cyc = 0;
    while (BUSY === 1'b0 && idle_cyc < 10) begin tick(); idle_cyc++; end
    TX_VALID = 1'b0;
    n_checks++;
    if (idle_cyc != 1) begin
      n_fail++; $display("FAIL b2b_idle_gap: idle cycles=%0d want 1", idle_cyc);
    end
    rx_half(d2, p2, ok2, s2);
    rx_half(d3, p3, ok3, s3);
    n_checks++;
    if (d0 !== 16'hFFFF || p0 !== 1'b1 || d1 !== 16'h0000 || p1 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_word0: %h/%b %h/%b want FFFF/1 0000/1", d0, p0, d1, p1);
    end
    n_checks++;
    if (d2 !== 16'h0000 || p2 !== 1'b1 || d3 !== 16'h0001 || p3 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_word1: %h/%b %h/%b want 0000/1 0001/0", d2, p2, d3, p3);
    end
    n_checks++;
    if (!(ok0 && ok1 && ok2 && ok3 && s0 && s1 && s2 && s3)) begin
      n_fail++; $display("FAIL b2b_stable: ok=%b%b%b%b stable=%b%b%b%b want all 1",
                         ok0, ok1, ok2, ok3, s0, s1, s2, s3);
    end
    n = 0;
    while (BUSY !== 1'b0 && n < 10) begin tick(); n++; end
  endtask

  task automatic wait_stb_high();
    int n;
    n = 0;
    while (RIB_STB !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++;
    if (RIB_STB !== 1'b1) begin
      n_fail++; $display("FAIL wait_stb: STB=%b want 1 within 20 cycles", RIB_STB);
    end
  endtask

  task automatic test_timeout();
    send_word(32'hCAFE0001);
    wait_stb_high();
    repeat (1022) tick();
    n_checks++;
    if (TX_ERR !== 1'b0 || RIB_STB !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: ERR=%b STB=%b after 1022 cycles, want 0 1", TX_ERR, RIB_STB);
    end
    tick();
    n_checks++;
    if (TX_ERR !== 1'b1 || RIB_STB !== 1'b0 || BUSY !== 1'b0 || TX_READY !== 1'b0) begin
      n_fail++; $display("FAIL timeout_fire: ERR=%b STB=%b BUSY=%b RDY=%b want 1 0 0 0",
                         TX_ERR, RIB_STB, BUSY, TX_READY);
    end
    repeat (5) tick();
    n_checks++;
    if (TX_ERR !== 1'b1 || TX_READY !== 1'b0) begin
      n_fail++; $display("FAIL timeout_sticky: ERR=%b RDY=%b want 1 0", TX_ERR, TX_READY);
    end
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    n_checks++;
    if (TX_ERR !== 1'b0 || TX_READY !== 1'b1) begin
      n_fail++; $display("FAIL timeout_clear: ERR=%b RDY=%b want 0 1", TX_ERR, TX_READY);
    end
  endtask

  task automatic test_err_clr_collision();
    send_word(32'h0F0F0F0F);
    wait_stb_high();
    repeat (1022) tick();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    n_checks++;
    if (TX_ERR !== 1'b1) begin
      n_fail++; $display("FAIL collision_set_wins: ERR=%b want 1", TX_ERR);
    end
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    n_checks++;
    if (TX_ERR !== 1'b0) begin
      n_fail++; $display("FAIL collision_clear: ERR=%b want 0", TX_ERR);
    end
  endtask

  task automatic test_ack_stuck();
    int bad;
    RIB_ACK = 1'b1;
    tick(); tick();
    TX_DATA = 32'h11112222; TX_VALID = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (TX_READY !== 1'b0 || BUSY !== 1'b0 || TX_ERR !== 1'b0) bad++;
    end
    TX_VALID = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL ack_stuck: %0d cycles with ready/busy/err set, want 0", bad);
    end
    RIB_ACK = 1'b0;
    tick();
    n_checks++;
    if (TX_READY !== 1'b0) begin
      n_fail++; $display("FAIL ack_release_early: RDY=%b one cycle after release, want 0", TX_READY);
    end
    tick(); tick();
    n_checks++;
    if (TX_READY !== 1'b1) begin
      n_fail++; $display("FAIL ack_release: RDY=%b three cycles after release, want 1", TX_READY);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; logic par; bit ok, st; int n;
    send_word(32'h5A5A3C3C);
    rx_half(d, par, ok, st);
    n_checks++;
    if (!ok || d !== 16'h3C3C || par !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_low: D=%h PAR=%b ok=%b want 3C3C 1 1", d, par, ok);
    end
    wait_stb_high();
    #2;
    RESET_N = 1'b0;
    #1;
    n_checks++;
    if (RIB_STB !== 1'b0 || RIB_D !== 16'h0000 || RIB_PAR !== 1'b1 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: STB=%b D=%h PAR=%b BUSY=%b want 0 0000 1 0",
                         RIB_STB, RIB_D, RIB_PAR, BUSY);
    end
    tick();
    RESET_N = 1'b1;
    tick();
    send_word(32'h87654321);
    rx_half(d, par, ok, st);
    n_checks++;
    if (!ok || !st || d !== 16'h4321 || par !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_new_low: D=%h PAR=%b ok=%b stable=%b want 4321 0 1 1", d, par, ok, st);
    end
    rx_half(d, par, ok, st);
    n_checks++;
    if (!ok || !st || d !== 16'h8765 || par !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_new_high: D=%h PAR=%b ok=%b stable=%b want 8765 1 1 1", d, par, ok, st);
    end
    n = 0;
    while (BUSY !== 1'b0 && n < 10) begin tick(); n++; end
    n_checks++;
    if (BUSY !== 1'b0 || TX_READY !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_done: BUSY=%b RDY=%b want 0 1", BUSY, TX_READY);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_err_clr_collision();
    test_ack_stuck();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
